// File: rtl/axis_usb_packetizer_pkg.sv
// Shared constants and helpers for the USB bulk-IN packetizer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axis_usb_packetizer_pkg;

    // Bulk endpoint max packet sizes for high-speed and full-speed links
    localparam int USB_HS_MAX_PKT = 512;
    localparam int USB_FS_MAX_PKT = 64;

    // Idle timer width; keeps at least one bit when the timeout is disabled
    function automatic int idle_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/axis_usb_packetizer.sv
// Splits a byte stream into USB bulk packets: tlast on MAX_PKT bytes, upstream tlast or idle timeout.
// Latency: non-last byte leaves 1 cycle after its successor is accepted; last byte 2 cycles after acceptance.
// Backpressure: two-stage hold/output register; s_axis_tready drops only when both stages are full and m_axis stalls.
module axis_usb_packetizer
    import axis_usb_packetizer_pkg::*;
#(
    parameter bit HIGH_SPEED     = 1'b1,
    parameter int MAX_PKT        = HIGH_SPEED ? USB_HS_MAX_PKT : USB_FS_MAX_PKT,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       timeout_flush,
    output logic       pkt_done
);

    localparam int                CNT_W      = $clog2(MAX_PKT);
    localparam int                IDLE_W     = idle_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MAX_PKT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
    localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    // Stage A holds the newest byte until we know whether it ends a packet
    logic              a_valid;
    logic [7:0]        a_data;
    logic              a_last;
    // Stage B is the output register driving m_axis directly
    logic              b_valid;
    logic [7:0]        b_data;
    logic              b_last;

    logic [CNT_W-1:0]  cnt;
    logic [IDLE_W-1:0] idle;

    logic              b_free;
    logic              accept;
    logic              in_last;
    logic              move;
    logic              fire;

    // Handshake and stage-transfer decisions
    always_comb begin
        b_free        = !b_valid | m_axis_tready;
        s_axis_tready = !a_valid | !b_valid | m_axis_tready;
        accept        = s_axis_tvalid & s_axis_tready;
        in_last       = s_axis_tlast | (cnt == CNT_LAST);
        // A non-last byte only leaves A once a successor proves it is not the last one
        move          = a_valid & b_free & (a_last | accept);
        // A simultaneous accept takes priority over the idle timeout
        fire          = TIMEOUT_EN & a_valid & !a_last & !accept & (idle == IDLE_LIMIT);
    end

    // Stage A load, drain and timeout close, plus the in-packet byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_data  <= 8'h00;
            a_last  <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_valid <= 1'b1;
            a_data  <= s_axis_tdata;
            a_last  <= in_last;
            cnt     <= in_last ? '0 : cnt + 1'b1;
        end else if (move) begin
            a_valid <= 1'b0;
        end else if (fire) begin
            a_last  <= 1'b1;
            cnt     <= '0;
        end
    end

    // Idle timer runs only while a non-last byte waits in A with no new input
    always_ff @(posedge clk) begin
        if (rst) begin
            idle          <= '0;
            timeout_flush <= 1'b0;
        end else begin
            timeout_flush <= fire;
            if (!TIMEOUT_EN || accept || !a_valid || a_last || fire) begin
                idle <= '0;
            end else begin
                idle <= idle + 1'b1;
            end
        end
    end

    // Stage B output register: load from A or drain on a downstream handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid <= 1'b0;
            b_data  <= 8'h00;
            b_last  <= 1'b0;
        end else if (move) begin
            b_valid <= 1'b1;
            b_data  <= a_data;
            b_last  <= a_last;
        end else if (m_axis_tready) begin
            b_valid <= 1'b0;
        end
    end

    // Output drive and end-of-packet beat indication
    always_comb begin
        m_axis_tvalid = b_valid;
        m_axis_tdata  = b_data;
        m_axis_tlast  = b_last;
        pkt_done      = b_valid & m_axis_tready & b_last;
    end

endmodule

// File: tb/tb_axis_usb_packetizer.sv
// Scoreboard bench for the USB bulk packetizer (512-byte packets, 16-cycle timeout plus a timeout-disabled instance).
// Latency: expected beats queued at acceptance, popped by an independent monitor on each output handshake.
// Backpressure: random m_axis_tready phase checks data stability while stalled.
module tb_axis_usb_packetizer;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic       clk;
    logic       rst;

    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       s_tlast;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;
    logic       flush;
    logic       done;

    logic [7:0] s0_tdata;
    logic       s0_tvalid;
    logic       s0_tready;
    logic       s0_tlast;
    logic [7:0] m0_tdata;
    logic       m0_tvalid;
    logic       m0_tready;
    logic       m0_tlast;
    logic       flush0;
    logic       done0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pos = 0;
    int acc_cyc = 0;
    int tlast_cyc = 0;
    int flush_cyc = 0;
    int done_cnt = 0;
    int flush_cnt = 0;
    int v0_cnt = 0;
    int b0_cnt = 0;
    int f0_cnt = 0;
    int d0_cnt = 0;
    bit rnd_mode = 1'b0;

    beat_t q[$];
    beat_t q0[$];

    axis_usb_packetizer #(
        .HIGH_SPEED    (1'b1),
        .MAX_PKT       (512),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .timeout_flush(flush),
        .pkt_done     (done)
    );

    axis_usb_packetizer #(
        .HIGH_SPEED    (1'b1),
        .MAX_PKT       (512),
        .TIMEOUT_CYCLES(0)
    ) dut0 (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s0_tdata),
        .s_axis_tvalid(s0_tvalid),
        .s_axis_tready(s0_tready),
        .s_axis_tlast (s0_tlast),
        .m_axis_tdata (m0_tdata),
        .m_axis_tvalid(m0_tvalid),
        .m_axis_tready(m0_tready),
        .m_axis_tlast (m0_tlast),
        .timeout_flush(flush0),
        .pkt_done     (done0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the main instance: scoreboard pop, stall stability, pulse counting
    initial begin
        beat_t e;
        bit    prev_stall;
        logic [7:0] prev_d;
        logic  prev_l;
        prev_stall = 1'b0;
        prev_d = 8'h00;
        prev_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", int'(m_tvalid), 1);
                    check("stall_data", int'(m_tdata), int'(prev_d));
                    check("stall_last", int'(m_tlast), int'(prev_l));
                end
                if (m_tvalid && m_tready) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_beat: got data %0d with empty scoreboard", m_tdata);
                    end else begin
                        e = q.pop_front();
                        check("beat_data", int'(m_tdata), int'(e.d));
                        check("beat_last", int'(m_tlast), int'(e.l));
                    end
                    if (m_tlast) tlast_cyc = cyc;
                end
                if (done) done_cnt++;
                if (flush) begin
                    flush_cnt++;
                    flush_cyc = cyc;
                end
                prev_stall = m_tvalid && !m_tready;
                prev_d = m_tdata;
                prev_l = m_tlast;
            end
        end
    end

    // Monitor for the timeout-disabled instance
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m0_tvalid) v0_cnt++;
                if (flush0) f0_cnt++;
                if (done0) d0_cnt++;
                if (m0_tvalid && m0_tready) begin
                    b0_cnt++;
                    if (q0.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_beat0: got data %0d with empty scoreboard", m0_tdata);
                    end else begin
                        e = q0.pop_front();
                        check("beat0_data", int'(m0_tdata), int'(e.d));
                        check("beat0_last", int'(m0_tlast), int'(e.l));
                    end
                end
            end
        end
    end

    // Random downstream backpressure, forced ready every 4th cycle so the idle timer never expires
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) m_tready = ((cyc % 4) == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Offer one byte; expected tlast = upstream tlast, 512th byte of packet, or a known timeout close
    task automatic send(input logic [7:0] d, input logic tl, input bit to_last);
        int   guard;
        logic el;
        guard = 0;
        s_tvalid = 1'b1;
        s_tdata = d;
        s_tlast = tl;
        @(negedge clk);
        while (!s_tready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_tready) begin
            tests++;
            fails++;
            $display("FAIL send_ready: got tready 0 for 200 cycles, required 1");
        end else begin
            el = tl | (pos == 511) | to_last;
            q.push_back('{d, el});
            acc_cyc = cyc;
            pos = el ? 0 : pos + 1;
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic send0(input logic [7:0] d, input logic el);
        int guard;
        guard = 0;
        s0_tvalid = 1'b1;
        s0_tdata = d;
        s0_tlast = 1'b0;
        @(negedge clk);
        while (!s0_tready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s0_tready) begin
            tests++;
            fails++;
            $display("FAIL send0_ready: got tready 0 for 200 cycles, required 1");
        end else begin
            q0.push_back('{d, el});
        end
        @(posedge clk);
        #1;
        s0_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (q.size() != 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        #1;
        check(name, q.size(), 0);
        idle(3);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        s_tdata = 8'h00;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        s0_tdata = 8'h00;
        s0_tvalid = 1'b0;
        s0_tlast = 1'b0;
        m0_tready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", int'(m_tvalid), 0);
        check("rst_m_last", int'(m_tlast), 0);
        check("rst_m_data", int'(m_tdata), 0);
        check("rst_flush", int'(flush), 0);
        check("rst_pkt_done", int'(done), 0);
        check("rst_s_ready", int'(s_tready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: 1024 contiguous bytes, tlast on beats 512 and 1024
        done_cnt = 0;
        for (int i = 0; i < 1024; i++) send(8'(i), 1'b0, 1'b0);
        drain("t1_drain");
        check("t1_pkt_done", done_cnt, 2);

        // 2: three bytes then idle; the third closes after 16 idle cycles.
        // Accept window k, timer reaches 16 in window k+17, flush visible k+18, beat k+19.
        flush_cnt = 0;
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        send(8'hA3, 1'b0, 1'b1);
        t = acc_cyc;
        drain("t2_drain");
        check("t2_flush_count", flush_cnt, 1);
        check("t2_flush_delay", flush_cyc - t, 18);
        check("t2_tlast_delay", tlast_cyc - t, 19);

        // 3: five bytes, upstream tlast on the fifth
        flush_cnt = 0;
        done_cnt = 0;
        for (int i = 1; i <= 5; i++) send(8'(8'h30 + i), (i == 5), 1'b0);
        t = acc_cyc;
        drain("t3_drain");
        check("t3_tlast_delay", tlast_cyc - t, 2);
        check("t3_flush_count", flush_cnt, 0);
        check("t3_pkt_done", done_cnt, 1);

        // 4: 2000 random bytes with random gaps and random backpressure; final byte carries tlast
        flush_cnt = 0;
        done_cnt = 0;
        rnd_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            idle($urandom_range(0, 2));
            send(8'($urandom), (i == 1999), 1'b0);
        end
        drain("t4_drain");
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        check("t4_pkt_done", done_cnt, 4);
        check("t4_flush_count", flush_cnt, 0);

        // 5: reset after byte 200 of a packet, then a fresh 512-byte packet
        for (int i = 0; i < 200; i++) send(8'(i + 7), 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        pos = 0;
        @(negedge clk);
        check("t5_rst_valid", int'(m_tvalid), 0);
        check("t5_rst_last", int'(m_tlast), 0);
        check("t5_rst_data", int'(m_tdata), 0);
        @(posedge clk);
        #1;
        done_cnt = 0;
        for (int i = 0; i < 512; i++) send(8'(255 - i), 1'b0, 1'b0);
        t = acc_cyc;
        drain("t5_drain");
        check("t5_pkt_done", done_cnt, 1);
        check("t5_tlast_delay", tlast_cyc - t, 2);

        // 6: timeout disabled; a lone byte waits until its successor releases it without tlast
        send0(8'h5A, 1'b0);
        v0_cnt = 0;
        idle(10000);
        check("t6_idle_valid", v0_cnt, 0);
        send0(8'h5B, 1'b0);
        idle(5);
        check("t6_beats", b0_cnt, 1);
        check("t6_pending", q0.size(), 1);
        check("t6_flush0", f0_cnt, 0);
        check("t6_done0", d0_cnt, 0);

        check("final_queue", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
